// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and frame-boundary constants for the SPI register bridge.
package tft_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } spi_state_e;

  localparam int         CMD_READ_BIT = 7;
  localparam logic [5:0] BITS_CMD     = 6'd8;
  localparam logic [5:0] BITS_HDR     = 6'd16;
  localparam logic [5:0] BITS_FRAME   = 6'd48;

  // States in which incoming sclk bits are still being consumed.
  function automatic logic is_active(input spi_state_e s);
    return (s == CMD) || (s == ADDR) || (s == WDATA) || (s == RDATA);
  endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register-bus bundle between the SPI bridge (master) and the register file (slave).
interface spi_reg_bridge_if;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_write;
  logic        reg_read;
  logic [31:0] reg_rdata;

  modport master (output reg_addr, output reg_wdata, output reg_write,
                  output reg_read, input reg_rdata);
  modport slave  (input reg_addr, input reg_wdata, input reg_write,
                  input reg_read, output reg_rdata);
endinterface

// File: rtl/spi_reg_bridge_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with single-clk rise/fall pulses.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q, sync_d;
  logic         prev_q, prev_d;

  // Next value of the synchronizer chain and the edge-history flop.
  always_comb begin
    sync_d = {sync_q[N-2:0], d};
    prev_d = sync_q[N-1];
  end

  // Synchronizer and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[N-1];
  assign rise = sync_q[N-1] & ~prev_q;
  assign fall = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that decodes host frames into single-cycle register-bus strobes.
// Optional idle-abort counter is built when SPI_TIMEOUT_EN is defined.
module spi_reg_bridge
  import tft_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic             busy,
  output logic             frame_err,
  spi_reg_bridge_if.master bus
);

  logic sclk_rise_s, sclk_fall_s, sclk_q_unused_s;
  logic cs_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk),
    .q(sclk_q_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n),
    .q(cs_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi),
    .q(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
  );

  spi_state_e  state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] tx_q, tx_d;
  logic        cmd_rd_q, cmd_rd_d;
  logic [7:0]  hdr_addr_q, hdr_addr_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic        reg_write_q, reg_write_d;
  logic        reg_read_q, reg_read_d;
  logic        frame_err_q, frame_err_d;
  logic        miso_q, miso_d;
  logic        miso_oe_q, miso_oe_d;
  logic        busy_q, busy_d;

`ifdef SPI_TIMEOUT_EN
  localparam logic [15:0] IDLE_LIM = 16'(TIMEOUT_CYC - 1);
  logic [15:0] idle_q, idle_d;
`else
  logic [15:0] timeout_unused_s;
  assign timeout_unused_s = 16'(TIMEOUT_CYC);
`endif

  // Frame decoder: next state, shift registers and strobe requests.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    cmd_rd_d    = cmd_rd_q;
    hdr_addr_d  = hdr_addr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_write_d = 1'b0;
    reg_read_d  = 1'b0;
    frame_err_d = 1'b0;

    // cs_n rising aborts whatever is in flight, including a 48th bit seen this clk.
    if (cs_rise_s) begin
      state_d   = IDLE;
      bit_cnt_d = 6'd0;
    end else if (cs_fall_s) begin
      state_d   = CMD;
      bit_cnt_d = 6'd0;
      rx_d      = 32'd0;
    end else if (reg_read_q) begin
      tx_d = bus.reg_rdata;
    end else if (sclk_rise_s && is_active(state_q)) begin
      rx_d      = {rx_q[30:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 6'd1;
      case (state_q)
        CMD: begin
          if (bit_cnt_d != BITS_CMD) begin
            state_d = CMD;
          end else if (rx_d[6:0] == 7'd0) begin
            state_d  = ADDR;
            cmd_rd_d = rx_d[CMD_READ_BIT];
          end else begin
            state_d     = DONE;
            frame_err_d = 1'b1;
          end
        end
        ADDR: begin
          if (bit_cnt_d != BITS_HDR) begin
            state_d = ADDR;
          end else if (cmd_rd_q) begin
            state_d    = RDATA;
            hdr_addr_d = rx_d[7:0];
            reg_addr_d = rx_d[7:0];
            reg_read_d = 1'b1;
          end else begin
            state_d    = WDATA;
            hdr_addr_d = rx_d[7:0];
          end
        end
        WDATA: begin
          if (bit_cnt_d == BITS_FRAME) begin
            state_d     = DONE;
            reg_addr_d  = hdr_addr_q;
            reg_wdata_d = rx_d;
            reg_write_d = 1'b1;
          end else begin
            state_d = WDATA;
          end
        end
        RDATA: begin
          if (bit_cnt_d == BITS_FRAME) begin
            state_d = DONE;
          end else begin
            state_d = RDATA;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (sclk_fall_s && (state_q == RDATA) && (bit_cnt_q > BITS_HDR)) begin
      // The 16th falling edge only presents rdata[31]; later ones advance.
      tx_d = {tx_q[30:0], 1'b0};
    end else begin
      state_d = state_q;
    end

`ifdef SPI_TIMEOUT_EN
    if (cs_s || sclk_rise_s || sclk_fall_s) begin
      idle_d = 16'd0;
    end else begin
      idle_d = idle_q + 16'd1;
    end
    if (!cs_s && !sclk_rise_s && !sclk_fall_s && is_active(state_q) && (idle_q == IDLE_LIM)) begin
      state_d     = DONE;
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = frame_err_d;
    end
`endif

    miso_oe_d = (state_d == RDATA);
    miso_d    = (state_d == RDATA) ? tx_d[31] : 1'b0;
    busy_d    = ~cs_s;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 6'd0;
      rx_q        <= 32'd0;
      tx_q        <= 32'd0;
      cmd_rd_q    <= 1'b0;
      hdr_addr_q  <= 8'd0;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 32'd0;
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_TIMEOUT_EN
      idle_q      <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cmd_rd_q    <= cmd_rd_d;
      hdr_addr_q  <= hdr_addr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_write_q <= reg_write_d;
      reg_read_q  <= reg_read_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      busy_q      <= busy_d;
`ifdef SPI_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_write = reg_write_q;
  assign bus.reg_read  = reg_read_q;
  assign spi_miso      = miso_q;
  assign spi_miso_oe   = miso_oe_q;
  assign busy          = busy_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed vector table plus random frames vs a frame-level model.
module tb_spi_reg_bridge;

  localparam int HALF = 10;  // sclk half period in clk cycles
`ifdef SPI_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, busy, frame_err;

  spi_reg_bridge_if bus_if ();

  spi_reg_bridge #(.SYNC_STAGES(2), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .busy(busy), .frame_err(frame_err),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  // Register-file responder and strobe monitor
  logic [31:0] resp_mem [256];
  logic [31:0] ref_mem  [256];
  assign bus_if.reg_rdata = resp_mem[bus_if.reg_addr];

  int checks = 0, failures = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, spacing_bad = 0;
  logic [7:0]  last_waddr = 8'd0, last_raddr = 8'd0;
  logic [31:0] last_wdata = 32'd0;
  logic        prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (bus_if.reg_write) begin
      wr_cnt = wr_cnt + 1;
      last_waddr = bus_if.reg_addr;
      last_wdata = bus_if.reg_wdata;
      resp_mem[bus_if.reg_addr] = bus_if.reg_wdata;
    end
    if (bus_if.reg_read) begin
      rd_cnt = rd_cnt + 1;
      last_raddr = bus_if.reg_addr;
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if ((bus_if.reg_write && bus_if.reg_read) ||
        ((bus_if.reg_write || bus_if.reg_read) && prev_strobe)) spacing_bad = spacing_bad + 1;
    prev_strobe = bus_if.reg_write | bus_if.reg_read;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] data;
    int          nbits;
    int          gap;
    int          stall;
    bit          exp_w;
    bit          exp_r;
    bit          exp_e;
    logic [31:0] exp_wdata;
    logic [31:0] exp_miso;
    int          exp_oe;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data,
                              input int nbits, input int gap, input int stall,
                              input bit w, input bit r, input bit e,
                              input logic [31:0] wd, input logic [31:0] mi, input int oe);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.data = data; v.nbits = nbits; v.gap = gap; v.stall = stall;
    v.exp_w = w; v.exp_r = r; v.exp_e = e; v.exp_wdata = wd; v.exp_miso = mi; v.exp_oe = oe;
    return v;
  endfunction

  // Frame-level reference: outcome follows from command byte and how many bits the host clocked.
  function automatic vec_t model(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data,
                                 input int nbits, input int gap);
    bit bad, rd;
    bad = (cmd[6:0] != 7'd0);
    rd  = cmd[7];
    return mk(cmd, addr, data, nbits, gap, 0,
              !bad && !rd && nbits == 48, !bad && rd && nbits >= 16, bad && nbits >= 8,
              data, ref_mem[addr], (!bad && rd && nbits > 16) ? nbits - 16 : 0);
  endfunction

  // Host side of one mode-0 frame; MISO is sampled just before each rising edge.
  task automatic run_frame(input vec_t v, output logic [31:0] miso_word, output int oe_cnt,
                           output int oe_early, output int miso_bad, output logic busy_mid);
    logic [47:0] bits;
    bits = {v.cmd, v.addr, v.data};
    miso_word = 32'd0; oe_cnt = 0; oe_early = 0; miso_bad = 0; busy_mid = 1'b0;
    spi_cs_n = 1'b0;
    for (int i = 0; i < v.nbits; i++) begin
      spi_mosi = bits[47 - i];
      repeat (HALF) @(negedge clk);
      if (i == 0) busy_mid = busy;
      if (spi_miso_oe) begin
        oe_cnt = oe_cnt + 1;
        if (i < 16) oe_early = oe_early + 1;
      end else if (spi_miso) begin
        miso_bad = miso_bad + 1;
      end
      if (i >= 16) miso_word = {miso_word[30:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (HALF + v.stall) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (v.gap) @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int w0, r0, e0, oe_cnt, oe_early, miso_bad;
    logic [31:0] mw;
    logic bm;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    run_frame(v, mw, oe_cnt, oe_early, miso_bad, bm);
    chk({tag, " write_pulses"}, 32'(wr_cnt - w0), 32'(v.exp_w));
    chk({tag, " read_pulses"}, 32'(rd_cnt - r0), 32'(v.exp_r));
    chk({tag, " frame_err_pulses"}, 32'(err_cnt - e0), 32'(v.exp_e));
    if (v.exp_w) begin
      chk({tag, " write_addr"}, 32'(last_waddr), 32'(v.addr));
      chk({tag, " write_data"}, last_wdata, v.exp_wdata);
      ref_mem[v.addr] = v.exp_wdata;
    end
    if (v.exp_r) chk({tag, " read_addr"}, 32'(last_raddr), 32'(v.addr));
    if (v.exp_r && v.nbits == 48) chk({tag, " miso_word"}, mw, v.exp_miso);
    chk({tag, " miso_oe_bits"}, 32'(oe_cnt), 32'(v.exp_oe));
    chk({tag, " miso_oe_early"}, 32'(oe_early), 32'd0);
    chk({tag, " miso_idle_zero"}, 32'(miso_bad), 32'd0);
    chk({tag, " busy_in_frame"}, 32'(bm), 32'd1);
    if (v.gap >= 8) chk({tag, " busy_after"}, 32'(busy), 32'd0);
  endtask

  vec_t tbl [11];

  initial begin
    vec_t v;
    int r;
    logic [7:0] c;

    for (int i = 0; i < 256; i++) begin
      resp_mem[i] = 32'd0;
      ref_mem[i]  = 32'd0;
    end
    resp_mem[8'hFE] = 32'h56313030;
    ref_mem[8'hFE]  = 32'h56313030;

    tbl[0]  = mk(8'h00, 8'h02, 32'h00000005, 48, 10, 0,   1, 0, 0, 32'h00000005, 32'h0, 0);
    tbl[1]  = mk(8'h80, 8'hFE, 32'h00000000, 48, 10, 0,   0, 1, 0, 32'h0, 32'h56313030, 32);
    tbl[2]  = mk(8'h00, 8'h10, 32'hDEADBEEF, 40, 10, 0,   0, 0, 0, 32'h0, 32'h0, 0);
    tbl[3]  = mk(8'h00, 8'h10, 32'h000000AB, 48, 10, 0,   1, 0, 0, 32'h000000AB, 32'h0, 0);
    tbl[4]  = mk(8'h01, 8'h33, 32'h00000000, 48, 10, 0,   0, 0, 1, 32'h0, 32'h0, 0);
    tbl[5]  = mk(8'h00, 8'h04, 32'h12345678, 48, 3, 0,    1, 0, 0, 32'h12345678, 32'h0, 0);
    tbl[6]  = mk(8'h80, 8'h04, 32'h00000000, 48, 10, 0,   0, 1, 0, 32'h0, 32'h12345678, 32);
    tbl[7]  = mk(8'h80, 8'h10, 32'h00000000, 48, 10, 0,   0, 1, 0, 32'h0, 32'h000000AB, 32);
    tbl[8]  = mk(8'h40, 8'h00, 32'h00000000, 7, 10, 0,    0, 0, 0, 32'h0, 32'h0, 0);
    tbl[9]  = mk(8'h80, 8'h04, 32'h00000000, 24, 10, 0,   0, 1, 0, 32'h0, 32'h0, 8);
    tbl[10] = mk(8'h00, 8'h05, 32'h00000000, 20, 10, 140, 0, 0, TO_EN, 32'h0, 32'h0, 0);

    repeat (5) @(negedge clk);
    chk("reset reg_write", 32'(bus_if.reg_write), 32'd0);
    chk("reset reg_read", 32'(bus_if.reg_read), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset miso", {30'd0, spi_miso_oe, spi_miso}, 32'd0);
    chk("reset reg_addr", 32'(bus_if.reg_addr), 32'd0);
    chk("reset reg_wdata", bus_if.reg_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 11; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 20; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) c = 8'h00;
      else if (r < 8) c = 8'h80;
      else c = {1'b0 + 1'($urandom_range(0, 1)), 7'($urandom_range(1, 127))};
      v = model(c, 8'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 47)) : 48,
                int'($urandom_range(3, 12)));
      apply_vec(v, $sformatf("rnd%0d", n));
    end

    chk("strobe_spacing", 32'(spacing_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
